// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and producer indices
package regfile_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam int SRC_ALU    = 0;
    localparam int SRC_LOAD   = 1;
    localparam int SRC_MULDIV = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter, search starts at rr_ptr
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic             found;
    int               gidx;
    int               idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = 0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= PTR_W'((gidx + 1) % N);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter and busy scoreboard for the register file write port
// Optional same-cycle read bypass ports enabled by WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::NUM_REGS;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    output logic                      issue_conflict,
    output logic [NUM_REGS-1:0]       busy,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]         byp_addr1,
    input  logic [ADDR_W-1:0]         byp_addr2,
    output logic                      byp_hit1,
    output logic                      byp_hit2,
    output logic [DATA_W-1:0]         byp_data1,
    output logic [DATA_W-1:0]         byp_data2,
`endif
    output logic                      wr_en3,
    output logic [ADDR_W-1:0]         wr_addr3,
    output logic [DATA_W-1:0]         wr_data3
);
    logic [NUM_SRC-1:0]  hold_v;
    logic [ADDR_W-1:0]   hold_addr [NUM_SRC];
    logic [DATA_W-1:0]   hold_data [NUM_SRC];
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  grant;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = hold_v[i] && (hold_addr[i] != '0);
        end
    end

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .grant (grant)
    );

    assign src_ready = ~hold_v | grant;

    // Address-0 entries never win arbitration, so they are retired here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_addr[i] <= '0;
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    hold_v[i]    <= 1'b1;
                    hold_addr[i] <= src_addr[i*ADDR_W +: ADDR_W];
                    hold_data[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i] || (hold_v[i] && hold_addr[i] == '0)) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        wr_addr3 = '0;
        wr_data3 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                wr_addr3 = wr_addr3 | hold_addr[i];
                wr_data3 = wr_data3 | hold_data[i];
            end
        end
    end

    assign wr_en3 = |grant;

    // Set after clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en3) begin
            busy_nxt[wr_addr3] = 1'b0;
        end
        if (issue_valid && issue_addr != '0) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign issue_conflict = busy[issue_addr] && (issue_addr != '0);

`ifdef WB_BYPASS_EN
    assign byp_hit1  = wr_en3 && (wr_addr3 == byp_addr1) && (byp_addr1 != '0);
    assign byp_hit2  = wr_en3 && (wr_addr3 == byp_addr2) && (byp_addr2 != '0);
    assign byp_data1 = byp_hit1 ? wr_data3 : '0;
    assign byp_data2 = byp_hit2 ? wr_data3 : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int NUM_SRC = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      issue_valid;
    logic [ADDR_W-1:0]         issue_addr;
    logic                      issue_conflict;
    logic [31:0]               busy;
    logic                      wr_en3;
    logic [ADDR_W-1:0]         wr_addr3;
    logic [DATA_W-1:0]         wr_data3;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0]         byp_addr1, byp_addr2;
    logic                      byp_hit1, byp_hit2;
    logic [DATA_W-1:0]         byp_data1, byp_data2;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .issue_valid    (issue_valid),
        .issue_addr     (issue_addr),
        .issue_conflict (issue_conflict),
        .busy           (busy),
`ifdef WB_BYPASS_EN
        .byp_addr1      (byp_addr1),
        .byp_addr2      (byp_addr2),
        .byp_hit1       (byp_hit1),
        .byp_hit2       (byp_hit2),
        .byp_data1      (byp_data1),
        .byp_data2      (byp_data2),
`endif
        .wr_en3         (wr_en3),
        .wr_addr3       (wr_addr3),
        .wr_data3       (wr_data3)
    );

    task automatic clear_inputs();
        src_valid   = '0;
        src_addr    = '0;
        src_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
`ifdef WB_BYPASS_EN
        byp_addr1   = '0;
        byp_addr2   = '0;
`endif
    endtask

    // Leaves the bench 1 time unit into cycle 0 with reset released.
    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int s, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        src_valid[s] = 1'b1;
        src_addr[s*ADDR_W +: ADDR_W] = a;
        src_data[s*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        tests_run++;
        if (busy !== 32'h0 || wr_en3 !== 1'b0 || src_ready !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_asserted busy=%h wr_en3=%b src_ready=%b required 0/0/111", busy, wr_en3, src_ready);
        end
        apply_reset();
        #2;
        tests_run++;
        if (busy !== 32'h0 || wr_en3 !== 1'b0 || wr_addr3 !== 5'd0 || wr_data3 !== 32'h0 ||
            src_ready !== 3'b111 || issue_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release busy=%h wr_en3=%b addr=%0d data=%h ready=%b conf=%b required all 0, ready 111",
                     busy, wr_en3, wr_addr3, wr_data3, src_ready, issue_conflict);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        offer(0, 5'd5, 32'hDEADBEEF);
        #2;
        tests_run++;
        if (wr_en3 !== 1'b0 || src_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_c0 wr_en3=%b ready0=%b required 0/1", wr_en3, src_ready[0]);
        end
        tick();
        clear_inputs();
        #2;
        tests_run++;
        if (wr_en3 !== 1'b1 || wr_addr3 !== 5'd5 || wr_data3 !== 32'hDEADBEEF || src_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_c1 wr_en3=%b addr=%0d data=%h ready0=%b required 1/5/deadbeef/1",
                     wr_en3, wr_addr3, wr_data3, src_ready[0]);
        end
        tick();
        #2;
        tests_run++;
        if (wr_en3 !== 1'b0 || wr_data3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL single_c2 wr_en3=%b data=%h required 0/0", wr_en3, wr_data3);
        end
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] exp_addr [3];
        logic [2:0]        exp_rdy  [3];
        exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd3;
        exp_rdy[0]  = 3'b001; exp_rdy[1] = 3'b011; exp_rdy[2] = 3'b111;
        apply_reset();
        offer(0, 5'd1, 32'h11);
        offer(1, 5'd2, 32'h22);
        offer(2, 5'd3, 32'h33);
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            #2;
            tests_run++;
            if (wr_en3 !== 1'b1 || wr_addr3 !== exp_addr[c] || src_ready !== exp_rdy[c]) begin
                tests_failed++;
                $display("FAIL contention_c%0d wr_en3=%b addr=%0d ready=%b required 1/%0d/%b",
                         c + 1, wr_en3, wr_addr3, src_ready, exp_addr[c], exp_rdy[c]);
            end
            tick();
        end
        // Pointer back at 0: src 0 must beat src 2.
        offer(0, 5'd8, 32'h88);
        offer(2, 5'd9, 32'h99);
        #2;
        tests_run++;
        if (wr_en3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_idle wr_en3=%b required 0", wr_en3);
        end
        tick();
        clear_inputs();
        #2;
        tests_run++;
        if (wr_addr3 !== 5'd8 || wr_data3 !== 32'h88) begin
            tests_failed++;
            $display("FAIL rr_ptr_wrap addr=%0d data=%h required 8/88", wr_addr3, wr_data3);
        end
        tick();
        #2;
        tests_run++;
        if (wr_addr3 !== 5'd9 || wr_en3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_second addr=%0d wr_en3=%b required 9/1", wr_addr3, wr_en3);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        offer(0, 5'd10, 32'hA0);
        tick();
        offer(0, 5'd11, 32'hA1);
        #2;
        tests_run++;
        if (wr_addr3 !== 5'd10 || src_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_c1 addr=%0d ready0=%b required 10/1", wr_addr3, src_ready[0]);
        end
        tick();
        clear_inputs();
        #2;
        tests_run++;
        if (wr_en3 !== 1'b1 || wr_addr3 !== 5'd11 || wr_data3 !== 32'hA1) begin
            tests_failed++;
            $display("FAIL b2b_c2 wr_en3=%b addr=%0d data=%h required 1/11/a1", wr_en3, wr_addr3, wr_data3);
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        #2;
        tests_run++;
        if (issue_conflict !== 1'b0 || busy !== 32'h0) begin
            tests_failed++;
            $display("FAIL sb_c0 conf=%b busy=%h required 0/0", issue_conflict, busy);
        end
        tick();
        issue_valid = 1'b0;
        offer(1, 5'd7, 32'h77);
        #2;
        tests_run++;
        if (busy !== 32'h80 || issue_conflict !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_set busy=%h conf=%b required 00000080/1", busy, issue_conflict);
        end
        tick();
        clear_inputs();
        issue_addr = 5'd7;
        #2;
        tests_run++;
        if (wr_en3 !== 1'b1 || wr_addr3 !== 5'd7 || busy !== 32'h80) begin
            tests_failed++;
            $display("FAIL sb_wr_cycle wr_en3=%b addr=%0d busy=%h required 1/7/00000080", wr_en3, wr_addr3, busy);
        end
        tick();
        #2;
        tests_run++;
        if (busy !== 32'h0 || issue_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_clear busy=%h conf=%b required 0/0", busy, issue_conflict);
        end
        offer(1, 5'd7, 32'h78);
        tick();
        src_valid   = '0;
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        #2;
        tests_run++;
        if (wr_en3 !== 1'b1 || wr_addr3 !== 5'd7) begin
            tests_failed++;
            $display("FAIL sb_rewrite wr_en3=%b addr=%0d required 1/7", wr_en3, wr_addr3);
        end
        tick();
        issue_valid = 1'b0;
        #2;
        tests_run++;
        if (busy !== 32'h80) begin
            tests_failed++;
            $display("FAIL sb_set_wins busy=%h required 00000080", busy);
        end
    endtask

    task automatic test_addr0();
        apply_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        offer(0, 5'd0, 32'h5555);
        tick();
        clear_inputs();
        #2;
        tests_run++;
        if (wr_en3 !== 1'b0 || src_ready[0] !== 1'b0 || busy !== 32'h8) begin
            tests_failed++;
            $display("FAIL addr0_held wr_en3=%b ready0=%b busy=%h required 0/0/00000008", wr_en3, src_ready[0], busy);
        end
        tick();
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        #2;
        tests_run++;
        if (wr_en3 !== 1'b0 || src_ready[0] !== 1'b1 || busy !== 32'h8 || issue_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr0_freed wr_en3=%b ready0=%b busy=%h conf=%b required 0/1/00000008/0",
                     wr_en3, src_ready[0], busy, issue_conflict);
        end
        tick();
        issue_valid = 1'b0;
        #2;
        tests_run++;
        if (busy !== 32'h8 || wr_en3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr0_issue busy=%h wr_en3=%b required 00000008/0", busy, wr_en3);
        end
    endtask

    task automatic test_reset_midflight();
        int writes = 0;
        apply_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        offer(0, 5'd4, 32'h44);
        offer(1, 5'd5, 32'h55);
        tick();
        clear_inputs();
        #2;
        tests_run++;
        if (wr_en3 !== 1'b1 || busy !== 32'h10) begin
            tests_failed++;
            $display("FAIL mid_pre wr_en3=%b busy=%h required 1/00000010", wr_en3, busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (wr_en3 !== 1'b0 || busy !== 32'h0 || src_ready !== 3'b111) begin
            tests_failed++;
            $display("FAIL mid_async wr_en3=%b busy=%h ready=%b required 0/0/111", wr_en3, busy, src_ready);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            if (wr_en3 !== 1'b0) writes++;
            tick();
        end
        tests_run++;
        if (writes != 0 || busy !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_after writes=%0d busy=%h required 0/0", writes, busy);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        apply_reset();
        byp_addr1 = 5'd5;
        byp_addr2 = 5'd0;
        offer(0, 5'd5, 32'h1234);
        #2;
        tests_run++;
        if (byp_hit1 !== 1'b0 || byp_data1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL byp_idle hit1=%b data1=%h required 0/0", byp_hit1, byp_data1);
        end
        tick();
        clear_inputs();
        byp_addr1 = 5'd5;
        #2;
        tests_run++;
        if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h1234 || byp_hit2 !== 1'b0 || byp_data2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL byp_hit hit1=%b data1=%h hit2=%b data2=%h required 1/1234/0/0",
                     byp_hit1, byp_data1, byp_hit2, byp_data2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_scoreboard();
        test_addr0();
        test_reset_midflight();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file's single write port. It accepts write-back requests from NUM_SRC producers (ALU, load unit, multiply/divide), buffers one request per producer, and grants the port round-robin, one write per cycle. It also tracks pending destination registers so decode can detect hazards. It sits between the execution units and the register file, and directly drives wr_en3/wr_addr3/wr_data3.

## Interface
Parameters:
- NUM_SRC, 3, number of write-back producers (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports (clock and reset first):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  single clock, rising edge
  - rst_n  in  1  asynchronous active-low reset
- Producer side:
  - src_valid  in  NUM_SRC  producer i offers a write
  - src_ready  out  NUM_SRC  producer i handshake completes when valid&ready
  - src_addr  in  NUM_SRC*ADDR_W  destination per producer, slice i at [i*ADDR_W +: ADDR_W]
  - src_data  in  NUM_SRC*DATA_W  data per producer, slice i at [i*DATA_W +: DATA_W]
- Decode side:
  - issue_valid  in  1  decode issues an instruction with destination issue_addr
  - issue_addr  in  ADDR_W  issued destination register
  - issue_conflict  out  1  combinational: busy[issue_addr] and issue_addr!=0
  - busy  out  32  scoreboard, bit r = write to r pending
- Register file side:
  - wr_en3  out  1  register file write enable
  - wr_addr3  out  ADDR_W  register file write address
  - wr_data3  out  DATA_W  register file write data

## Operation
- Per producer: one holding entry {hold_v, hold_addr, hold_data}.
  - src_ready[i] = !hold_v[i] | grant[i].
  - On handshake, the entry is loaded at the clock edge.
- Eligible entry: hold_v[i] && hold_addr[i]!=0.
- Address-0 entries are dropped: hold_v is cleared the next cycle, no grant is issued, and no wr_en3 is asserted.
- Arbitration is round-robin over eligible entries, searching from rr_ptr upward modulo NUM_SRC.
  - At most one grant per cycle.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_SRC.
  - rr_ptr is unchanged when nothing is granted.
- Write port is combinational from the granted entry:
  - wr_en3 = |grant
  - wr_addr3 and wr_data3 come from the granted entry
  - Both are 0 when no entry is granted.
- A granted entry may be refilled by the same producer in the same cycle, giving back-to-back throughput.
- Scoreboard:
  - On issue_valid with issue_addr!=0, set busy[issue_addr].
  - On wr_en3, clear busy[wr_addr3].
  - If set and clear hit the same register in the same cycle, set wins.
  - busy[0] is always 0.
- A write to a non-busy register is legal and leaves busy unchanged.
- Decode must not issue while issue_conflict is high; the block does not enforce this.

## Timing
- Reset values:
  - hold_v=0, rr_ptr=0, busy=0.
  - All outputs are 0 except src_ready, which is all 1.
- Latency: a handshake in cycle N gives wr_en3 in cycle N+1 at the earliest; the register file captures at the end of N+1.
- busy clears at the edge ending the wr_en3 cycle.
- Worst-case wait with all producers continuously eligible: NUM_SRC-1 cycles.
- Reset mid-operation discards held entries and all pending busy bits immediately, asynchronously.

## Configuration
- WB_BYPASS_EN defined: adds the following ports.
  - byp_addr1, byp_addr2  in  ADDR_W
  - byp_hit1, byp_hit2  out  1
  - byp_data1, byp_data2  out  DATA_W
  - byp_hitk = wr_en3 && wr_addr3==byp_addrk && byp_addrk!=0.
  - byp_datak = wr_data3 when hit, else 0.
  - All combinational, so decode can use a value written in the same cycle.
- WB_BYPASS_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W and NUM_REGS=32
  - producer index constants SRC_ALU=0, SRC_LOAD=1, SRC_MULDIV=2
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N-1:0], clk, rst_n
  - outputs: one-hot grant
  - holds rr_ptr internally
- Holding entries, scoreboard and write mux stay in the top.

## Test plan
- Reset release: busy=0, wr_en3=0, src_ready=3'b111 → all hold.
- Single write: ALU offers addr 5, data 0xDEADBEEF in cycle 0 → cycle 1 has wr_en3=1, wr_addr3=5, wr_data3=0xDEADBEEF; src_ready[0]=1 throughout.
- Contention: all three offer in cycle 0 (addrs 1, 2, 3) → grants to src 0, 1, 2 in cycles 1, 2, 3.
  - src_ready[1] is low in cycle 1; src_ready[2] is low in cycles 1–2.
  - rr_ptr returns to 0.
- Scoreboard: issue addr 7 in cycle 0 → busy[7]=1 and issue_conflict=1 for addr 7.
  - The load write to 7 clears busy[7] after its wr_en3 cycle.
  - Issuing 7 during that same wr_en3 cycle leaves busy[7]=1.
- Address 0: a producer offers addr 0 → no wr_en3, entry freed next cycle, busy unchanged; issue addr 0 is ignored.
- Reset mid-flight: assert rst_n=0 with two entries held and busy[4]=1 → wr_en3 drops immediately and busy=0; no writes occur after release.
- With WB_BYPASS_EN: byp_addr1=5 during a write of 5 with data 0x1234 → byp_hit1=1, byp_data1=0x1234; byp_addr2=0 → byp_hit2=0.
